// File: rtl/ref_window_fetcher_if.sv
// rtl/ref_window_fetcher_if.sv - block start, frame memory read and line stream bundle
interface ref_window_fetcher_if #(
  parameter int ADDR_W = 12
);
  logic                start;
  logic [7:0]          coord_x;
  logic [7:0]          coord_y;
  logic signed [14:0]  mv_x_integer;
  logic signed [14:0]  mv_y_integer;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_rd_data;
  logic [71:0]         line_out;
  logic                line_valid;
  logic                line_pop;
  logic                busy;
  logic                done;

  modport slave (
    input  start, coord_x, coord_y, mv_x_integer, mv_y_integer, mem_rd_data, line_pop,
    output mem_rd_en, mem_addr, line_out, line_valid, busy, done
  );

  modport master (
    output start, coord_x, coord_y, mv_x_integer, mv_y_integer, mem_rd_data, line_pop,
    input  mem_rd_en, mem_addr, line_out, line_valid, busy, done
  );
endinterface

// File: rtl/ref_window_fetcher.sv
// rtl/ref_window_fetcher.sv - fetches a clamped 9x9 reference window and streams it as 9 lines
module ref_window_fetcher #(
  parameter int FRAME_W    = 64,
  parameter int FRAME_H    = 64,
  parameter int ADDR_W     = 12,
  parameter int WIN        = 9,
  parameter int TAP_OFF    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ref_window_fetcher_if.slave  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST = 4'(WIN - 1);

  typedef enum logic [2:0] {IDLE, CALC, FETCH, HOLD, DRAIN} state_t;

  state_t             state;
  logic               busy_r, done_r, rd_en_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [7:0]         lat_x, lat_y;
  logic [14:0]        lat_mvx, lat_mvy;
  logic signed [16:0] x0, y0, x0_c, y0_c;
  logic [3:0]         row_cnt, col_cnt, pop_cnt;
  logic [CNT_W-1:0]   asm_cnt, count;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               rd_en_q, rd_last_q;
  logic [63:0]        shreg;
  logic [71:0]        fifo_mem [FIFO_DEPTH];
  logic               pop_fire, push, slot_free, start_line;
  logic [CNT_W:0]     occ;

  // Clamping each coordinate into the frame replicates edge samples.
  function automatic logic [ADDR_W-1:0] win_addr(input logic signed [16:0] ox, input logic signed [16:0] oy,
                                                 input logic [3:0] r, input logic [3:0] c);
    logic signed [16:0] px, py;
    logic [ADDR_W-1:0]  col, row;
    px = ox + $signed({13'd0, c});
    py = oy + $signed({13'd0, r});
    if (px < 0)                col = '0;
    else if (px > FRAME_W - 1) col = ADDR_W'(FRAME_W - 1);
    else                       col = px[ADDR_W-1:0];
    if (py < 0)                row = '0;
    else if (py > FRAME_H - 1) row = ADDR_W'(FRAME_H - 1);
    else                       row = py[ADDR_W-1:0];
    return row * ADDR_W'(FRAME_W) + col;
  endfunction

  always_comb begin
    x0_c = $signed({9'd0, lat_x}) + $signed({{2{lat_mvx[14]}}, lat_mvx}) - 17'(TAP_OFF);
    y0_c = $signed({9'd0, lat_y}) + $signed({{2{lat_mvy[14]}}, lat_mvy}) - 17'(TAP_OFF);
  end

  assign pop_fire  = bus.line_pop && (count != '0);
  assign push      = rd_last_q;
  // A same-cycle pop counts as a free slot; a same-cycle push just moves a line from assembly to FIFO.
  assign occ       = (CNT_W+1)'(count) + (CNT_W+1)'(asm_cnt) - (CNT_W+1)'(pop_fire);
  assign slot_free = occ < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    start_line = 1'b0;
    case (state)
      CALC:    start_line = 1'b1;
      FETCH:   start_line = (col_cnt == LAST) && (row_cnt != LAST) && slot_free;
      HOLD:    start_line = slot_free;
      default: start_line = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rd_en_r <= 1'b0;
      addr_r  <= '0;
      lat_x   <= '0;
      lat_y   <= '0;
      lat_mvx <= '0;
      lat_mvy <= '0;
      x0      <= '0;
      y0      <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      pop_cnt <= '0;
      asm_cnt <= '0;
    end else begin
      done_r  <= 1'b0;
      asm_cnt <= asm_cnt + CNT_W'(start_line) - CNT_W'(push);
      if (pop_fire) pop_cnt <= pop_cnt + 4'd1;
      case (state)
        IDLE: begin
          if (bus.start) begin
            lat_x   <= bus.coord_x;
            lat_y   <= bus.coord_y;
            lat_mvx <= bus.mv_x_integer;
            lat_mvy <= bus.mv_y_integer;
            busy_r  <= 1'b1;
            pop_cnt <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          x0      <= x0_c;
          y0      <= y0_c;
          rd_en_r <= 1'b1;
          addr_r  <= win_addr(x0_c, y0_c, 4'd0, 4'd0);
          row_cnt <= '0;
          col_cnt <= '0;
          state   <= FETCH;
        end
        FETCH: begin
          if (col_cnt != LAST) begin
            col_cnt <= col_cnt + 4'd1;
            addr_r  <= win_addr(x0, y0, row_cnt, col_cnt + 4'd1);
          end else if (row_cnt == LAST) begin
            rd_en_r <= 1'b0;
            state   <= DRAIN;
          end else begin
            row_cnt <= row_cnt + 4'd1;
            col_cnt <= '0;
            if (slot_free) begin
              addr_r <= win_addr(x0, y0, row_cnt + 4'd1, 4'd0);
            end else begin
              rd_en_r <= 1'b0;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            rd_en_r <= 1'b1;
            addr_r  <= win_addr(x0, y0, row_cnt, 4'd0);
            state   <= FETCH;
          end
        end
        DRAIN: begin
          if (pop_fire && pop_cnt == LAST) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lags the strobe by one cycle; samples enter on the right so sample 0 ends at the top byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q   <= 1'b0;
      rd_last_q <= 1'b0;
      shreg     <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      rd_en_q   <= rd_en_r;
      rd_last_q <= rd_en_r && (col_cnt == LAST);
      if (rd_en_q) shreg <= {shreg[55:0], bus.mem_rd_data};
      if (push) begin
        fifo_mem[wr_ptr] <= {shreg, bus.mem_rd_data};
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_fire) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop_fire);
    end
  end

  assign bus.mem_rd_en  = rd_en_r;
  assign bus.mem_addr   = addr_r;
  assign bus.line_out   = fifo_mem[rd_ptr];
  assign bus.line_valid = (count != '0);
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
endmodule

// File: tb/tb_ref_window_fetcher.sv
// tb/tb_ref_window_fetcher.sv - scoreboard bench for ref_window_fetcher
module tb_ref_window_fetcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ref_window_fetcher_if #(.ADDR_W(12)) bus();
  ref_window_fetcher dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_count, first_rd_cyc, last_rd_cyc, pop_n, last_pop_cyc, first_valid_cyc;
  logic [71:0] first_line;
  logic pop_en = 1'b0;
  logic [71:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: mem[a] = a[7:0], data one cycle after the strobe.
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];

  always @(negedge clk) begin
    if (bus.mem_rd_en) begin
      rd_count = rd_count + 1;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
    end
  end

  // Consumer: pops whenever enabled and compares each popped line with the scoreboard head.
  always @(negedge clk) begin
    if (bus.line_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pop_en && bus.line_valid && !rst) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL line_unexpected: got %h, scoreboard empty", bus.line_out);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        if (bus.line_out !== e) begin
          errors = errors + 1;
          $display("FAIL line_data[%0d]: got %h expected %h", pop_n, bus.line_out, e);
        end
      end
      if (pop_n == 0) first_line = bus.line_out;
      pop_n = pop_n + 1;
      last_pop_cyc = cyc;
      bus.line_pop = 1'b1;
    end else begin
      bus.line_pop = 1'b0;
    end
  end

  function automatic logic [71:0] model_line(int cx, int cy, int mvx, int mvy, int r);
    int x0, y0, row, col;
    logic [71:0] l;
    x0 = cx + mvx - 2;
    y0 = cy + mvy - 2;
    row = y0 + r;
    if (row < 0) row = 0;
    if (row > 63) row = 63;
    l = '0;
    for (int c = 0; c < 9; c++) begin
      col = x0 + c;
      if (col < 0) col = 0;
      if (col > 63) col = 63;
      l = {l[63:0], 8'((row * 64 + col) & 255)};
    end
    return l;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_block(input int cx, input int cy, input int mvx, input int mvy,
                             input bit expect_lines, output int start_cyc);
    if (expect_lines) begin
      for (int r = 0; r < 9; r++) exp_q.push_back(model_line(cx, cy, mvx, mvy, r));
      rd_count = 0;
      first_rd_cyc = -1;
      first_valid_cyc = -1;
      pop_n = 0;
    end
    bus.coord_x = 8'(cx);
    bus.coord_y = 8'(cy);
    bus.mv_x_integer = 15'(mvx);
    bus.mv_y_integer = 15'(mvy);
    bus.start = 1'b1;
    start_cyc = cyc;
    tick();
    bus.start = 1'b0;
    bus.coord_x = 8'hAA;
    bus.coord_y = 8'h55;
    bus.mv_x_integer = 15'd7;
    bus.mv_y_integer = -15'sd9;
  endtask

  task automatic wait_done(input string tag, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < 600 && done_cyc < 0; i++) begin
      @(negedge clk);
      if (bus.done) done_cyc = cyc;
      #1;
    end
    checks = checks + 1;
    if (done_cyc < 0) begin
      errors = errors + 1;
      $display("FAIL %s_done_timeout: no DONE within 600 cycles, required DONE", tag);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.coord_x = '0;
    bus.coord_y = '0;
    bus.mv_x_integer = '0;
    bus.mv_y_integer = '0;
    bus.line_pop = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks = checks + 5;
    if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL reset_line_valid: got %b required 0", bus.line_valid); end
    if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    if (bus.done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b required 0", bus.done); end
    if (bus.mem_rd_en !== 1'b0)  begin errors++; $display("FAIL reset_rd_en: got %b required 0", bus.mem_rd_en); end
    if (bus.line_out !== 72'd0)  begin errors++; $display("FAIL reset_line_out: got %h required 0", bus.line_out); end
  endtask

  task automatic test_centered();
    int s, d;
    pop_en = 1'b1;
    start_block(8, 8, 0, 0, 1'b1, s);
    wait_done("centered", d);
    checks = checks + 7;
    if (first_rd_cyc - s !== 2)       begin errors++; $display("FAIL centered_rd_latency: got %0d required 2", first_rd_cyc - s); end
    if (first_valid_cyc - s !== 12)   begin errors++; $display("FAIL centered_valid_latency: got %0d required 12", first_valid_cyc - s); end
    if (rd_count !== 81)              begin errors++; $display("FAIL centered_reads: got %0d required 81", rd_count); end
    if (last_rd_cyc - first_rd_cyc !== 80) begin errors++; $display("FAIL centered_read_span: got %0d required 80", last_rd_cyc - first_rd_cyc); end
    if (d - last_pop_cyc !== 1)       begin errors++; $display("FAIL centered_done_timing: got %0d required 1", d - last_pop_cyc); end
    if (first_line !== 72'h868788898A8B8C8D8E) begin errors++; $display("FAIL centered_line0: got %h required 868788898a8b8c8d8e", first_line); end
    if (bus.busy !== 1'b0)            begin errors++; $display("FAIL centered_busy_after: got %b required 0", bus.busy); end
  endtask

  task automatic test_clamp(input string tag, input int cx, input int cy, input int mvx, input int mvy);
    int s, d;
    pop_en = 1'b1;
    start_block(cx, cy, mvx, mvy, 1'b1, s);
    wait_done(tag, d);
    checks = checks + 2;
    if (pop_n !== 9)         begin errors++; $display("FAIL %s_lines: got %0d required 9", tag, pop_n); end
    if (exp_q.size() !== 0)  begin errors++; $display("FAIL %s_leftover: got %0d required 0", tag, exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int s, d;
    pop_en = 1'b0;
    start_block(5, 9, 3, -2, 1'b1, s);
    repeat (40) tick();
    checks = checks + 3;
    if (rd_count !== 18)        begin errors++; $display("FAIL bp_reads_stalled: got %0d required 18", rd_count); end
    if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en_low: got %b required 0", bus.mem_rd_en); end
    if (bus.line_valid !== 1'b1) begin errors++; $display("FAIL bp_line_valid: got %b required 1", bus.line_valid); end
    pop_en = 1'b1;
    tick();
    tick();
    pop_en = 1'b0;
    tick();
    checks = checks + 2;
    if (pop_n !== 2)             begin errors++; $display("FAIL bp_popped: got %0d required 2", pop_n); end
    if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL bp_buffered_two: got valid %b required 0", bus.line_valid); end
    pop_en = 1'b1;
    wait_done("bp", d);
    checks = checks + 2;
    if (rd_count !== 81) begin errors++; $display("FAIL bp_total_reads: got %0d required 81", rd_count); end
    if (pop_n !== 9)     begin errors++; $display("FAIL bp_lines: got %0d required 9", pop_n); end
  endtask

  task automatic test_reset_mid();
    int s, d;
    bit hit;
    pop_en = 1'b1;
    start_block(30, 12, -4, 6, 1'b1, s);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (rd_count >= 30) hit = 1'b1;
      else tick();
    end
    checks = checks + 1;
    if (!hit) begin errors++; $display("FAIL rstmid_reach_30: got %0d reads required 30", rd_count); end
    rst = 1'b1;
    #1;
    checks = checks + 3;
    if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL rstmid_line_valid: got %b required 0", bus.line_valid); end
    if (bus.busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy: got %b required 0", bus.busy); end
    if (bus.mem_rd_en !== 1'b0)  begin errors++; $display("FAIL rstmid_rd_en: got %b required 0", bus.mem_rd_en); end
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    start_block(20, 30, 7, -4, 1'b1, s);
    wait_done("rstmid", d);
    checks = checks + 2;
    if (rd_count !== 81) begin errors++; $display("FAIL rstmid_reads: got %0d required 81", rd_count); end
    if (pop_n !== 9)     begin errors++; $display("FAIL rstmid_lines: got %0d required 9", pop_n); end
  endtask

  task automatic test_start_busy();
    int s, s2, d;
    pop_en = 1'b1;
    start_block(16, 24, 1, 2, 1'b1, s);
    repeat (5) tick();
    start_block(40, 4, -6, 3, 1'b0, s2);
    repeat (20) tick();
    start_block(2, 50, 0, 0, 1'b0, s2);
    wait_done("busy", d);
    repeat (15) tick();
    checks = checks + 4;
    if (pop_n !== 9)             begin errors++; $display("FAIL busy_lines: got %0d required 9", pop_n); end
    if (rd_count !== 81)         begin errors++; $display("FAIL busy_reads: got %0d required 81", rd_count); end
    if (bus.busy !== 1'b0)       begin errors++; $display("FAIL busy_idle_after: got %b required 0", bus.busy); end
    if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL busy_no_extra: got %b required 0", bus.line_valid); end
  endtask

  initial begin
    rd_count = 0;
    first_rd_cyc = -1;
    last_rd_cyc = 0;
    pop_n = 0;
    last_pop_cyc = 0;
    first_valid_cyc = -1;
    first_line = '0;
    test_reset();
    test_centered();
    test_clamp("topleft", 0, 0, -3, -1);
    test_clamp("botright", 60, 60, 5, 5);
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
